// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_ctrl : sequencer for shift-add multiply / restoring divide datapath |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module muldiv_ctrl #(
  parameter int N_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  input  logic c,
  input  logic sub_ok,
  input  logic div_zero,
  output logic ld_multiplier,
  output logic ld_dividend,
  output logic ad,
  output logic su,
  output logic sh,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CNT_W = $clog2(N_BITS + 2);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(N_BITS);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD      = 4'd1,
    MUL_TEST  = 4'd2,
    MUL_ADD   = 4'd3,
    MUL_SHIFT = 4'd4,
    DIV_TEST  = 4'd5,
    DIV_SUB   = 4'd6,
    DIV_SHIFT = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op_q, op_q_nxt;
  logic             err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_q_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_q_nxt  = op_q;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (start) begin
          op_q_nxt = op;
          // Divide by zero skips the datapath entirely and reports through err.
          if (op && div_zero) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            err_nxt   = 1'b0;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = op_q ? DIV_TEST : MUL_TEST;
      end
      MUL_TEST:  state_nxt = c ? MUL_ADD : MUL_SHIFT;
      MUL_ADD:   state_nxt = MUL_SHIFT;
      MUL_SHIFT: begin
        cnt_nxt   = cnt + 1'b1;
        state_nxt = (cnt == MUL_LAST) ? DONE : MUL_TEST;
      end
      DIV_TEST:  state_nxt = sub_ok ? DIV_SUB : DIV_SHIFT;
      DIV_SUB:   state_nxt = DIV_SHIFT;
      DIV_SHIFT: begin
        cnt_nxt   = cnt + 1'b1;
        state_nxt = (cnt == DIV_LAST) ? DONE : DIV_TEST;
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_multiplier = (state == LOAD) && !op_q;
    ld_dividend   = (state == LOAD) && op_q;
    ad            = (state == MUL_ADD);
    su            = (state == DIV_SUB);
    sh            = (state == MUL_SHIFT) || (state == DIV_SHIFT);
    busy          = (state != IDLE);
    done          = (state == DONE);
  end

`ifndef SYNTHESIS
  a_c_known: assert property (@(posedge clk) disable iff (rst)
    (state == MUL_TEST) |-> !$isunknown(c));
  a_sub_ok_known: assert property (@(posedge clk) disable iff (rst)
    (state == DIV_TEST) |-> !$isunknown(sub_ok));
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_ctrl : directed vector bench for the multiply/divide sequencer   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic op = 1'b0;
  logic div_zero = 1'b0;
  logic c, sub_ok;
  logic ld_multiplier, ld_dividend, ad, su, sh, busy, done, err;

  muldiv_ctrl #(.N_BITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .c(c), .sub_ok(sub_ok),
    .div_zero(div_zero), .ld_multiplier(ld_multiplier), .ld_dividend(ld_dividend),
    .ad(ad), .su(su), .sh(sh), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Shift-register model: status bit presented is the pattern bit at the shift count.
  logic [4:0] pat = 5'b0;
  int sh_idx = 0;
  always_comb begin
    c      = (sh_idx < 5) ? pat[sh_idx] : 1'b0;
    sub_ok = c;
  end

  typedef struct {
    string      name;
    logic       op;
    logic       dz;
    logic [4:0] pat;
    int         t;
    int         ldm, ldd, ad, su, sh;
    logic       err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ldm, n_ldd, n_ad, n_su, n_sh;
  logic prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle sample at the falling edge, with strobe one-hot check.
  task automatic sample();
    @(negedge clk);
    check("strobe_onehot",
          32'($countones({ld_multiplier, ld_dividend, ad, su, sh}) <= 1), 32'd1);
    n_ldm += int'(ld_multiplier);
    n_ldd += int'(ld_dividend);
    n_ad  += int'(ad);
    n_su  += int'(su);
    n_sh  += int'(sh);
    if (sh) sh_idx++;
  endtask

  task automatic clear_counts();
    n_ldm = 0; n_ldd = 0; n_ad = 0; n_su = 0; n_sh = 0; sh_idx = 0;
  endtask

  task automatic run(input vec_t v);
    int t, busy_low;
    @(posedge clk);
    sample();
    check({v.name, "_err_hold"}, 32'(err), 32'(prev_err));
    clear_counts();
    pat = v.pat; op = v.op; div_zero = v.dz; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t = -1; busy_low = 0;
    for (int k = 0; k < 60; k++) begin
      sample();
      if (!busy) busy_low++;
      if (done) begin t = k; break; end
      @(posedge clk);
    end
    check({v.name, "_done_edge"}, 32'(t), 32'(v.t));
    check({v.name, "_busy"}, 32'(busy_low), 32'd0);
    check({v.name, "_ld_mul"}, 32'(n_ldm), 32'(v.ldm));
    check({v.name, "_ld_div"}, 32'(n_ldd), 32'(v.ldd));
    check({v.name, "_ad"}, 32'(n_ad), 32'(v.ad));
    check({v.name, "_su"}, 32'(n_su), 32'(v.su));
    check({v.name, "_sh"}, 32'(n_sh), 32'(v.sh));
    check({v.name, "_err"}, 32'(err), 32'(v.err));
    @(posedge clk);
    sample();
    check({v.name, "_idle_busy"}, 32'(busy), 32'd0);
    check({v.name, "_idle_done"}, 32'(done), 32'd0);
    prev_err = v.err;
  endtask

  vec_t vecs[5];

  initial begin
    int t;
    logic found;
    vecs[0] = '{"mul1011", 1'b0, 1'b0, 5'b01011, 12, 1, 0, 3, 0, 4, 1'b0};
    vecs[1] = '{"mul0000", 1'b0, 1'b0, 5'b00000,  9, 1, 0, 0, 0, 4, 1'b0};
    vecs[2] = '{"div10110",1'b1, 1'b0, 5'b01101, 14, 0, 1, 0, 3, 5, 1'b0};
    vecs[3] = '{"divzero", 1'b1, 1'b1, 5'b00000,  0, 0, 0, 0, 0, 0, 1'b1};
    vecs[4] = '{"mul1111", 1'b0, 1'b0, 5'b01111, 13, 1, 0, 4, 0, 4, 1'b0};

    // Reset state, observed before any clock edge.
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_strobes", 32'({ld_multiplier, ld_dividend, ad, su, sh}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_counts();

    foreach (vecs[i]) run(vecs[i]);

    // Asynchronous reset while in MUL_ADD.
    @(posedge clk);
    clear_counts();
    pat = 5'b01011; op = 1'b0; div_zero = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (ad) begin found = 1'b1; break; end
      @(posedge clk);
    end
    check("rst_mid_reach_add", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ad", 32'(ad), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_err = 1'b0;
    run(vecs[4]);

    // Start pulses while busy, then start held across DONE.
    @(posedge clk);
    sample();
    clear_counts();
    pat = 5'b00000; op = 1'b0; div_zero = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 op = 1'b1;
    t = -1;
    for (int k = 0; k < 40; k++) begin
      sample();
      if (done) begin t = k; break; end
      start = (k < 6) ? ~start : 1'b1;
      @(posedge clk);
    end
    start = 1'b1;
    check("held_first_done", 32'(t), 32'd9);
    check("held_first_ldm", 32'(n_ldm), 32'd1);
    check("held_first_ldd", 32'(n_ldd), 32'd0);
    @(posedge clk);
    sample();
    check("held_idle_busy", 32'(busy), 32'd0);
    clear_counts();
    @(posedge clk);
    #1 start = 1'b0;
    sample();
    check("held_second_load", 32'(ld_dividend), 32'd1);
    t = -1;
    for (int k = 1; k < 40; k++) begin
      @(posedge clk);
      sample();
      if (done) begin t = k; break; end
    end
    check("held_second_done", 32'(t), 32'd11);
    check("held_second_sh", 32'(n_sh), 32'd5);
    check("held_second_err", 32'(err), 32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
